// File: rtl/fuzzy_pkg.sv
// rtl/fuzzy_pkg.sv - shared FSM encoding, default widths and triangular degree function
package fuzzy_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EVAL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int FUZZY_WIDTH   = 3;
    localparam int NO_OF_MEMBERS = 7;
    localparam int FMAX          = (1 << FUZZY_WIDTH) - 1;
    localparam int IDXW          = $clog2(NO_OF_MEMBERS);

    // Wide integer arithmetic so the same function serves any instance width.
    function automatic int unsigned tri_degree(input int d, input int unsigned slope,
                                               input int unsigned shift, input int unsigned fmax);
        int unsigned a;
        int unsigned p;
        a = (d < 0) ? unsigned'(-d) : unsigned'(d);
        p = (a * slope) >> shift;
        return (p >= fmax) ? 32'd0 : fmax - p;
    endfunction

endpackage

// File: rtl/fuzzy_tri_degree.sv
// rtl/fuzzy_tri_degree.sv - combinational degree of one triangular member, with shoulder override
module fuzzy_tri_degree
    import fuzzy_pkg::*;
#(
    parameter int pDataWidth  = 4,
    parameter int pFuzzyWidth = 3,
    parameter int pSlopeWidth = 4,
    parameter int pSlopeShift = 1,
    parameter int pShoulders  = 1
) (
    input  logic signed [pDataWidth-1:0]  data,
    input  logic signed [pDataWidth-1:0]  center,
    input  logic        [pSlopeWidth-1:0] slope,
    input  logic                          is_first,
    input  logic                          is_last,
    output logic        [pFuzzyWidth-1:0] degree
);

    localparam int unsigned DEG_MAX = (32'd1 << pFuzzyWidth) - 32'd1;

    logic signed [pDataWidth:0] d;
    logic        [31:0]         raw;
    logic                       d_neg;
    logic                       d_zero;

    assign d      = {data[pDataWidth-1], data} - {center[pDataWidth-1], center};
    assign d_neg  = d[pDataWidth];
    assign d_zero = (d == '0);

    always_comb begin
        raw    = tri_degree(int'(d), 32'(slope), pSlopeShift, DEG_MAX);
        degree = raw[pFuzzyWidth-1:0];
        if (pShoulders != 0 && ((is_first && (d_neg || d_zero)) || (is_last && !d_neg)))
            degree = DEG_MAX[pFuzzyWidth-1:0];
    end

endmodule

// File: rtl/fuzzifier_engine.sv
// rtl/fuzzifier_engine.sv - sequential fuzzifier, one member per cycle with running argmax
module fuzzifier_engine
    import fuzzy_pkg::*;
#(
    parameter int pDataWidth   = 4,
    parameter int pFuzzyWidth  = 3,
    parameter int pNoOfMembers = 7,
    parameter int pSlopeWidth  = 4,
    parameter int pSlopeShift  = 1,
    parameter int pShoulders   = 1
) (
    input  logic                                  Clock,
    input  logic                                  Reset,
    input  logic                                  InValid,
    output logic                                  InReady,
    input  logic signed [pDataWidth-1:0]          Data,
    input  logic [pDataWidth*pNoOfMembers-1:0]    Centers,
    input  logic [pSlopeWidth*pNoOfMembers-1:0]   Slopes,
    output logic                                  ValidOut,
    output logic [pFuzzyWidth*pNoOfMembers-1:0]   FuzzyData,
    output logic [$clog2(pNoOfMembers)-1:0]       DominantIdx
);

    localparam int IDX_W = $clog2(pNoOfMembers);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(pNoOfMembers - 1);

    logic [1:0]                                state;
    logic [IDX_W-1:0]                          k;
    logic signed [pDataWidth-1:0]              data_q;
    logic [pDataWidth*pNoOfMembers-1:0]        centers_q;
    logic [pSlopeWidth*pNoOfMembers-1:0]       slopes_q;
    logic [pFuzzyWidth*pNoOfMembers-1:0]       work_q;
    logic [pFuzzyWidth-1:0]                    max_deg;
    logic [IDX_W-1:0]                          max_idx;
    logic [pFuzzyWidth-1:0]                    cur_deg;

    assign InReady = (state == ST_IDLE);

    fuzzy_tri_degree #(
        .pDataWidth  (pDataWidth),
        .pFuzzyWidth (pFuzzyWidth),
        .pSlopeWidth (pSlopeWidth),
        .pSlopeShift (pSlopeShift),
        .pShoulders  (pShoulders)
    ) u_tri (
        .data     (data_q),
        .center   (centers_q[k*pDataWidth +: pDataWidth]),
        .slope    (slopes_q[k*pSlopeWidth +: pSlopeWidth]),
        .is_first (k == '0),
        .is_last  (k == LAST),
        .degree   (cur_deg)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= ST_IDLE;
            k           <= '0;
            data_q      <= '0;
            centers_q   <= '0;
            slopes_q    <= '0;
            work_q      <= '0;
            max_deg     <= '0;
            max_idx     <= '0;
            ValidOut    <= 1'b0;
            FuzzyData   <= '0;
            DominantIdx <= '0;
        end else begin
            ValidOut <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (InValid) begin
                        data_q    <= Data;
                        centers_q <= Centers;
                        slopes_q  <= Slopes;
                        k         <= '0;
                        state     <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    work_q[k*pFuzzyWidth +: pFuzzyWidth] <= cur_deg;
                    // Member 0 seeds the max; later members win only on strictly greater.
                    if (k == '0 || cur_deg > max_deg) begin
                        max_deg <= cur_deg;
                        max_idx <= k;
                    end
                    if (k == LAST) state <= ST_DONE;
                    else           k     <= k + 1'b1;
                end
                ST_DONE: begin
                    FuzzyData   <= work_q;
                    DominantIdx <= max_idx;
                    ValidOut    <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fuzzifier_engine.sv
// tb/tb_fuzzifier_engine.sv - directed self-checking bench for fuzzifier_engine
module tb_fuzzifier_engine;

    localparam int N = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic signed [3:0] data = '0;
    logic [27:0]       centers;
    logic [27:0]       slopes;
    logic              in_ready, valid_out, in_ready_ns, valid_out_ns;
    logic [20:0]       fuzzy, fuzzy_ns;
    logic [2:0]        dom, dom_ns;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    fuzzifier_engine #(.pShoulders(1)) u_dut (
        .Clock(clk), .Reset(rst_n), .InValid(in_valid), .InReady(in_ready),
        .Data(data), .Centers(centers), .Slopes(slopes),
        .ValidOut(valid_out), .FuzzyData(fuzzy), .DominantIdx(dom)
    );

    fuzzifier_engine #(.pShoulders(0)) u_dut_ns (
        .Clock(clk), .Reset(rst_n), .InValid(in_valid), .InReady(in_ready_ns),
        .Data(data), .Centers(centers), .Slopes(slopes),
        .ValidOut(valid_out_ns), .FuzzyData(fuzzy_ns), .DominantIdx(dom_ns)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int deg(input logic [20:0] f, input int k);
        return int'(f[k*3 +: 3]);
    endfunction

    task automatic check_all(input string tag, input int e[7], input int e_dom);
        for (int k = 0; k < N; k++)
            check($sformatf("%s_k%0d", tag, k), deg(fuzzy, k), e[k]);
        check({tag, "_dom"}, int'(dom), e_dom);
    endtask

    // Offer one sample, return edges from accept edge until ValidOut is visible.
    task automatic run(input logic signed [3:0] x, output int lat);
        lat = -1;
        @(negedge clk);
        data = x;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (valid_out) begin
                lat = i;
                break;
            end
        end
    endtask

    int lat;
    int e1[7] = '{0, 0, 3, 7, 3, 0, 0};
    int e2[7] = '{0, 0, 1, 5, 5, 1, 0};
    int pt[2];
    int npulse;
    int leak;
    int late_pulse;

    initial begin
        for (int k = 0; k < N; k++) begin
            centers[k*4 +: 4] = 4'((k - 3) * 2);
            slopes[k*4 +: 4]  = 4'd4;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", int'(in_ready), 1);
        check("rst_valid", int'(valid_out), 0);
        check("rst_fuzzy", int'(fuzzy), 0);
        check("rst_dom", int'(dom), 0);
        @(negedge clk) rst_n = 1'b1;

        run(4'sd0, lat);
        check("t1_latency", lat, N + 1);
        check_all("t1", e1, 3);
        @(posedge clk);
        #1 check("t1_pulse_width", int'(valid_out), 0);

        run(4'sd1, lat);
        check("t2_latency", lat, N + 1);
        check_all("t2", e2, 3);

        run(-4'sd8, lat);
        check("t3_k0", deg(fuzzy, 0), 7);
        check("t3_k1", deg(fuzzy, 1), 0);
        check("t3_dom", int'(dom), 0);
        check("t3_ns_k0", deg(fuzzy_ns, 0), 3);

        run(4'sd7, lat);
        check("t4_k6", deg(fuzzy, 6), 7);
        check("t4_k5", deg(fuzzy, 5), 1);
        check("t4_k4", deg(fuzzy, 4), 0);
        check("t4_dom", int'(dom), 6);
        slopes[3*4 +: 4] = 4'd0;
        run(4'sd7, lat);
        check("t4_flat_k3", deg(fuzzy, 3), 7);
        check("t4_flat_k6", deg(fuzzy, 6), 7);
        check("t4_flat_dom", int'(dom), 3);
        slopes[3*4 +: 4] = 4'd4;

        @(negedge clk);
        data = 4'sd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("t5_ready_after_accept", int'(in_ready), 0);
        data = 4'sd2;
        npulse = 0;
        leak = 0;
        for (int i = 0; i < 40 && npulse < 2; i++) begin
            @(posedge clk);
            #1;
            if (valid_out) begin
                pt[npulse] = cyc;
                npulse++;
                if (npulse == 2) in_valid = 1'b0;
            end else if (npulse == 0 && in_ready) begin
                leak = 1;
            end
        end
        in_valid = 1'b0;
        check("t5_pulses", npulse, 2);
        check("t5_ready_low", leak, 0);
        check("t5_gap", pt[1] - pt[0], N + 2);
        check("t5_k3", deg(fuzzy, 3), 3);
        check("t5_k4", deg(fuzzy, 4), 7);
        check("t5_dom", int'(dom), 4);

        @(negedge clk);
        data = 4'sd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t6_fuzzy", int'(fuzzy), 0);
        check("t6_dom", int'(dom), 0);
        check("t6_valid", int'(valid_out), 0);
        check("t6_ready", int'(in_ready), 1);
        @(negedge clk) rst_n = 1'b1;
        late_pulse = 0;
        repeat (12) begin
            @(posedge clk);
            #1 if (valid_out) late_pulse = 1;
        end
        check("t6_no_pulse", late_pulse, 0);
        run(4'sd0, lat);
        check("t6_latency", lat, N + 1);
        check_all("t6", e1, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
